fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
IF-stage controller plus IF/ID pipeline register; it consumes the stall and flush requests produced by the hazard detection/NPC unit.
- Owns the PC.
- Drives a request/ready instruction-memory port.
- Holds a fetched word when decode is stalled.
- On flush, redirects the PC to the hazard unit's computed NPC and inserts a bubble into IF/ID.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset.
NOP_INST, 32'h0000_0000, instruction word placed in IF/ID for a bubble.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low
if_stall  input  1  hazard unit: hold IF/ID and PC
if_rst  input  1  hazard unit: flush IF/ID, redirect PC (jump or taken branch)
npc_in  input  32  redirect target, valid when if_rst=1
imem_req  output  1  instruction fetch request
imem_addr  output  32  fetch address; stable while imem_req=1 and imem_ready=0
imem_ready  input  1  memory response valid this cycle (completes request)
imem_rdata  input  32  instruction word, valid with imem_ready
if_id_inst  output  32  IF/ID instruction
if_id_pc  output  32  IF/ID PC+4 of that instruction (feeds NPC)
if_id_valid  output  1  IF/ID holds a real instruction
fetch_pc  output  32  current PC register

Behaviour:
Reset (rst=0 at an edge):
- pc=RESET_PC, state=IDLE, imem_req=0.
- if_id_inst=NOP_INST, if_id_pc=0, if_id_valid=0, hold buffer empty.

IDLE:
- Next cycle goes to FETCH. No request issued in IDLE.

FETCH:
- imem_req=1, imem_addr=pc. Zero-wait memory gives one instruction per cycle.
- Priority: if_rst > if_stall > normal.
- imem_ready=1, no stall/flush: IF/ID <= {imem_rdata, pc+4, valid=1}; pc <= pc+4; stay in FETCH (back-to-back).
- imem_ready=1, if_stall=1: word -> hold buffer; IF/ID unchanged; pc unchanged; go to HOLD.
- imem_ready=1, if_rst=1: response discarded; IF/ID <= bubble; pc <= npc_in; stay in FETCH, new address next cycle.
- imem_ready=0, if_rst=1: pc <= npc_in; IF/ID <= bubble; go to KILL. The outstanding request stays at its old address.
- imem_ready=0, if_stall=1: IF/ID held.
- imem_ready=0, neither stall nor flush: IF/ID <= bubble (valid=0).

HOLD:
- imem_req=0.
- if_stall=1: everything held; the stall may last any number of cycles (the hazard unit may stall twice for a branch).
- if_stall=0: IF/ID <= buffer {inst, pc+4, 1}; pc <= pc+4; go to FETCH.
- if_rst=1: buffer dropped; IF/ID <= bubble; pc <= npc_in; go to FETCH.

KILL:
- imem_req=1, imem_addr = the old address latched at flush.
- On imem_ready: data discarded; go to FETCH at pc.
- A further if_rst in KILL overwrites pc with the new npc_in.
- IF/ID stays a bubble unless if_stall=1, in which case it is held.

Arithmetic and reset rules:
- pc+4 wraps modulo 2^32; no alignment check.
- Reset mid-request abandons it; memory must tolerate the dropped request.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs stall_cycles[31:0] and flush_count[31:0].
- stall_cycles increments on every cycle with if_stall=1 and if_rst=0.
- flush_count increments on every cycle with if_rst=1.
- Both counters wrap and are cleared by rst.
- Undefined: the ports and counters are absent; functional behaviour is identical.

Decomposition:
Package fetch_pkg contains:
- state enum IDLE/FETCH/HOLD/KILL (2-bit);
- PC_STEP=4;
- a default NOP constant.

Sub-module fetch_hold_buf: a one-entry buffer holding {inst, pc+4} with load/clear/full. Everything else stays in fetch_ctrl.

Test Plan:
1. Reset, then imem_ready held 1 and rdata = addr: imem_addr 3000, 3004, 3008 on consecutive cycles; if_id_pc = 3004, 3008; valid=1 from the 3rd cycle.
2. if_stall for 3 cycles while ready=1 at 3008: state goes to HOLD; IF/ID holds 3008's predecessor; after release IF/ID = inst@3008 with pc 300C; no instruction lost or duplicated.
3. if_rst with npc_in=3100 while ready=1: next imem_addr=3100; if_id_valid=0 for one cycle; the fetched word is never seen in IF/ID.
4. if_rst with npc_in=3200 while ready=0 (2-cycle wait): KILL keeps addr at the old value until ready; then addr=3200; the discarded data never reaches IF/ID.
5. if_rst and if_stall both 1 in HOLD: flush wins; buffer dropped; pc=npc_in.
6. rst=0 asserted mid-request in KILL: the next cycle shows all reset values, and fetch restarts at 3000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF-stage controller.
// Optional FETCH_PERF_CNT_EN adds stall/flush counters to fetch_ctrl.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        KILL  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] PC_STEP     = 32'd4;
    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_DEFAULT  = 32'h0000_3000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        valid;
    } if_id_t;

    function automatic if_id_t bubble(input logic [31:0] nop);
        if_id_t b;
        b.inst  = nop;
        b.pc    = 32'h0;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer that parks a fetched word while decode is stalled.
// Holds {inst, pc+4}; clear takes priority over load.
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] inst_in,
    input  logic [31:0] pc4_in,
    output logic [31:0] inst,
    output logic [31:0] pc4,
    output logic        full
);

    logic [31:0] inst_q, inst_d;
    logic [31:0] pc4_q, pc4_d;
    logic        full_q, full_d;

    always_comb begin
        inst_d = inst_q;
        pc4_d  = pc4_q;
        full_d = full_q;
        if (clear) begin
            full_d = 1'b0;
        end else if (load) begin
            inst_d = inst_in;
            pc4_d  = pc4_in;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            inst_q <= NOP_DEFAULT;
            pc4_q  <= 32'h0;
            full_q <= 1'b0;
        end else begin
            inst_q <= inst_d;
            pc4_q  <= pc4_d;
            full_q <= full_d;
        end
    end

    assign inst = inst_q;
    assign pc4  = pc4_q;
    assign full = full_q;

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage controller and IF/ID register: PC, imem handshake, stall/flush.
// Define FETCH_PERF_CNT_EN to add stall_cycles / flush_count outputs.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PC_DEFAULT,
    parameter logic [31:0] NOP_INST = NOP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_stall,
    input  logic        if_rst,
    input  logic [31:0] npc_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
`endif
    output logic [31:0] fetch_pc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  kill_addr_q, kill_addr_d;
    if_id_t       if_id_q, if_id_d;

    logic         buf_load;
    logic         buf_clear;
    logic [31:0]  buf_inst;
    logic [31:0]  buf_pc4;
    logic         buf_full;
    logic [31:0]  pc_inc;

    assign pc_inc = pc_q + PC_STEP;

    fetch_hold_buf u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (buf_load),
        .clear   (buf_clear),
        .inst_in (imem_rdata),
        .pc4_in  (pc_inc),
        .inst    (buf_inst),
        .pc4     (buf_pc4),
        .full    (buf_full)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_addr_d = kill_addr_q;
        if_id_d     = if_id_q;
        buf_load    = 1'b0;
        buf_clear   = 1'b0;

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (if_rst) begin
                    pc_d    = npc_in;
                    if_id_d = bubble(NOP_INST);
                    if (!imem_ready) begin
                        // request still in flight: drain it at its old address
                        kill_addr_d = pc_q;
                        state_d     = KILL;
                    end
                end else if (if_stall) begin
                    if (imem_ready) begin
                        buf_load = 1'b1;
                        state_d  = HOLD;
                    end
                end else if (imem_ready) begin
                    if_id_d.inst  = imem_rdata;
                    if_id_d.pc    = pc_inc;
                    if_id_d.valid = 1'b1;
                    pc_d          = pc_inc;
                end else begin
                    if_id_d = bubble(NOP_INST);
                end
            end
            HOLD: begin
                if (if_rst) begin
                    buf_clear = 1'b1;
                    if_id_d   = bubble(NOP_INST);
                    pc_d      = npc_in;
                    state_d   = FETCH;
                end else if (!if_stall) begin
                    if (buf_full) begin
                        if_id_d.inst  = buf_inst;
                        if_id_d.pc    = buf_pc4;
                        if_id_d.valid = 1'b1;
                        pc_d          = pc_inc;
                    end
                    buf_clear = 1'b1;
                    state_d   = FETCH;
                end
            end
            KILL: begin
                if (if_rst) begin
                    pc_d = npc_in;
                end
                if (if_rst || !if_stall) begin
                    if_id_d = bubble(NOP_INST);
                end
                if (imem_ready) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            kill_addr_q <= RESET_PC;
            if_id_q     <= bubble(NOP_INST);
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_addr_q <= kill_addr_d;
            if_id_q     <= if_id_d;
        end
    end

    assign imem_req    = (state_q == FETCH) || (state_q == KILL);
    assign imem_addr   = (state_q == KILL) ? kill_addr_q : pc_q;
    assign if_id_inst  = if_id_q.inst;
    assign if_id_pc    = if_id_q.pc;
    assign if_id_valid = if_id_q.valid;
    assign fetch_pc    = pc_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (if_stall && !if_rst) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (if_rst) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= 32'h0;
            flush_cnt_q <= 32'h0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;
`endif

endmodule
